id_stage: RTL

//   Instruction-decode stage of the 5-stage MIPS pipeline. Consumes CUR_INS and NEXT_INS_ADR from the fetch

---
 rtl/id_stage_pkg.sv | 69 ++++++
 rtl/id_stage_reg_file.sv | 52 +++++
 rtl/id_stage.sv | 118 +++++++++++
 3 files changed

// File: rtl/id_stage_pkg.sv
// Shared decode definitions for the ID stage: opcodes, ALU_OP encodings and
// the EX_CTRL bit layout consumed by the EX stage.
package id_stage_pkg;

  localparam int unsigned REG_IDX_W = 5;
  localparam int unsigned CTRL_W    = 9;

  // EX_CTRL = {REG_WRITE,MEM_TO_REG,MEM_READ,MEM_WRITE,BRANCH,ALU_SRC,REG_DST,ALU_OP[1:0]}
  localparam int unsigned CTRL_REG_WRITE  = 8;
  localparam int unsigned CTRL_MEM_TO_REG = 7;
  localparam int unsigned CTRL_MEM_READ   = 6;
  localparam int unsigned CTRL_MEM_WRITE  = 5;
  localparam int unsigned CTRL_BRANCH     = 4;
  localparam int unsigned CTRL_ALU_SRC    = 3;
  localparam int unsigned CTRL_REG_DST    = 2;
  localparam int unsigned CTRL_ALU_OP_MSB = 1;
  localparam int unsigned CTRL_ALU_OP_LSB = 0;

  typedef enum logic [5:0] {
    OP_RTYPE = 6'b000000,
    OP_BEQ   = 6'b000100,
    OP_ADDI  = 6'b001000,
    OP_LW    = 6'b100011,
    OP_SW    = 6'b101011
  } opcode_e;

  typedef enum logic [1:0] {
    ALU_OP_ADD   = 2'b00,
    ALU_OP_SUB   = 2'b01,
    ALU_OP_FUNCT = 2'b10
  } alu_op_e;

  // Unknown opcodes decode to all-zero control, i.e. a NOP.
  function automatic logic [CTRL_W-1:0] decode_ctrl(input logic [5:0] opcode);
    logic [CTRL_W-1:0] c;
    c = '0;
    case (opcode)
      OP_RTYPE: begin
        c[CTRL_REG_WRITE] = 1'b1;
        c[CTRL_REG_DST]   = 1'b1;
        c[CTRL_ALU_OP_MSB:CTRL_ALU_OP_LSB] = ALU_OP_FUNCT;
      end
      OP_LW: begin
        c[CTRL_REG_WRITE]  = 1'b1;
        c[CTRL_MEM_TO_REG] = 1'b1;
        c[CTRL_MEM_READ]   = 1'b1;
        c[CTRL_ALU_SRC]    = 1'b1;
        c[CTRL_ALU_OP_MSB:CTRL_ALU_OP_LSB] = ALU_OP_ADD;
      end
      OP_SW: begin
        c[CTRL_MEM_WRITE] = 1'b1;
        c[CTRL_ALU_SRC]   = 1'b1;
        c[CTRL_ALU_OP_MSB:CTRL_ALU_OP_LSB] = ALU_OP_ADD;
      end
      OP_BEQ: begin
        c[CTRL_BRANCH] = 1'b1;
        c[CTRL_ALU_OP_MSB:CTRL_ALU_OP_LSB] = ALU_OP_SUB;
      end
      OP_ADDI: begin
        c[CTRL_REG_WRITE] = 1'b1;
        c[CTRL_ALU_SRC]   = 1'b1;
        c[CTRL_ALU_OP_MSB:CTRL_ALU_OP_LSB] = ALU_OP_ADD;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/id_stage_reg_file.sv
// 2R1W register file with async clear, hard-wired $0 and write-through
// bypass so a writeback in the same cycle is visible to the decoder.
module reg_file #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned NUM_REGS = 32,
  parameter int unsigned IDX_W    = $clog2(NUM_REGS)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [IDX_W-1:0]  rd_addr_1_i,
  input  logic [IDX_W-1:0]  rd_addr_2_i,
  output logic [DATA_W-1:0] rd_data_1_o,
  output logic [DATA_W-1:0] rd_data_2_o,
  input  logic              wr_en_i,
  input  logic [IDX_W-1:0]  wr_addr_i,
  input  logic [DATA_W-1:0] wr_data_i
);

  logic [DATA_W-1:0] mem_q [NUM_REGS];
  logic              wr_valid;

  assign wr_valid = wr_en_i && (wr_addr_i != '0);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        mem_q[i] <= '0;
      end
    end else if (wr_valid) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  always_comb begin
    rd_data_1_o = mem_q[rd_addr_1_i];
    if (rd_addr_1_i == '0) begin
      rd_data_1_o = '0;
    end else if (wr_valid && (wr_addr_i == rd_addr_1_i)) begin
      rd_data_1_o = wr_data_i;
    end
  end

  always_comb begin
    rd_data_2_o = mem_q[rd_addr_2_i];
    if (rd_addr_2_i == '0) begin
      rd_data_2_o = '0;
    end else if (wr_valid && (wr_addr_i == rd_addr_2_i)) begin
      rd_data_2_o = wr_data_i;
    end
  end

endmodule

// File: rtl/id_stage.sv
// MIPS instruction-decode stage: register read, main control decode,
// immediate sign-extension and the ID/EX pipeline register.
module id_stage
  import id_stage_pkg::*;
#(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned NUM_REGS = 32
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [31:0]          CUR_INS,
  input  logic [DATA_W-1:0]    NEXT_INS_ADR,
  input  logic                 HOLD,
  input  logic                 FLUSH,
  input  logic                 WB_REG_WRITE,
  input  logic [REG_IDX_W-1:0] WB_WRITE_REG,
  input  logic [DATA_W-1:0]    WB_WRITE_DATA,
  output logic [DATA_W-1:0]    EX_NEXT_ADR,
  output logic [DATA_W-1:0]    EX_RD_DATA_1,
  output logic [DATA_W-1:0]    EX_RD_DATA_2,
  output logic [DATA_W-1:0]    EX_IMM,
  output logic [REG_IDX_W-1:0] EX_RT,
  output logic [REG_IDX_W-1:0] EX_RD,
  output logic [5:0]           EX_FUNCT,
  output logic [CTRL_W-1:0]    EX_CTRL
);

  logic [DATA_W-1:0]    rs_data, rt_data, imm_ext;
  logic [CTRL_W-1:0]    ctrl_dec;

  logic [DATA_W-1:0]    next_adr_d, rd_data_1_d, rd_data_2_d, imm_d;
  logic [DATA_W-1:0]    next_adr_q, rd_data_1_q, rd_data_2_q, imm_q;
  logic [REG_IDX_W-1:0] rt_d, rd_d, rt_q, rd_q;
  logic [5:0]           funct_d, funct_q;
  logic [CTRL_W-1:0]    ctrl_d, ctrl_q;

  reg_file #(
    .DATA_W   (DATA_W),
    .NUM_REGS (NUM_REGS),
    .IDX_W    (REG_IDX_W)
  ) u_reg_file (
    .clk_i       (CLK),
    .rst_i       (RST),
    .rd_addr_1_i (CUR_INS[25:21]),
    .rd_addr_2_i (CUR_INS[20:16]),
    .rd_data_1_o (rs_data),
    .rd_data_2_o (rt_data),
    .wr_en_i     (WB_REG_WRITE),
    .wr_addr_i   (WB_WRITE_REG),
    .wr_data_i   (WB_WRITE_DATA)
  );

  assign ctrl_dec = decode_ctrl(CUR_INS[31:26]);
  assign imm_ext  = {{(DATA_W-16){CUR_INS[15]}}, CUR_INS[15:0]};

  // FLUSH outranks HOLD so a stalled stage can still be squashed.
  always_comb begin
    next_adr_d  = next_adr_q;
    rd_data_1_d = rd_data_1_q;
    rd_data_2_d = rd_data_2_q;
    imm_d       = imm_q;
    rt_d        = rt_q;
    rd_d        = rd_q;
    funct_d     = funct_q;
    ctrl_d      = ctrl_q;
    if (FLUSH) begin
      next_adr_d  = '0;
      rd_data_1_d = '0;
      rd_data_2_d = '0;
      imm_d       = '0;
      rt_d        = '0;
      rd_d        = '0;
      funct_d     = '0;
      ctrl_d      = '0;
    end else if (!HOLD) begin
      next_adr_d  = NEXT_INS_ADR;
      rd_data_1_d = rs_data;
      rd_data_2_d = rt_data;
      imm_d       = imm_ext;
      rt_d        = CUR_INS[20:16];
      rd_d        = CUR_INS[15:11];
      funct_d     = CUR_INS[5:0];
      ctrl_d      = ctrl_dec;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      next_adr_q  <= '0;
      rd_data_1_q <= '0;
      rd_data_2_q <= '0;
      imm_q       <= '0;
      rt_q        <= '0;
      rd_q        <= '0;
      funct_q     <= '0;
      ctrl_q      <= '0;
    end else begin
      next_adr_q  <= next_adr_d;
      rd_data_1_q <= rd_data_1_d;
      rd_data_2_q <= rd_data_2_d;
      imm_q       <= imm_d;
      rt_q        <= rt_d;
      rd_q        <= rd_d;
      funct_q     <= funct_d;
      ctrl_q      <= ctrl_d;
    end
  end

  assign EX_NEXT_ADR  = next_adr_q;
  assign EX_RD_DATA_1 = rd_data_1_q;
  assign EX_RD_DATA_2 = rd_data_2_q;
  assign EX_IMM       = imm_q;
  assign EX_RT        = rt_q;
  assign EX_RD        = rd_q;
  assign EX_FUNCT     = funct_q;
  assign EX_CTRL      = ctrl_q;

endmodule
